neighbor_table_ctrl: RTL and testbench
======================================

// Module: neighbor_table_ctrl
// PURPOSE
//   Sequences and arbitrates the neighbor-table banks (neighborID/clusterID/energyLeft/qValue) between two requesters.
//   UPD (Q-table update): find source ID; update that entry, else append one.
//   BEST (next-hop select): scan all entries, return the one with maximum Q-value.
//   Owns neighborCount and drives all bank wr_en/index lines.
// PARAMETERS
//   WORD_WIDTH     16       data word width; Q/energy unsigned Q2.14 (16'h4000 = 1.0)
//   MAX_NEIGHBORS  16       table depth
//   IDX_W          4        index width, clog2(MAX_NEIGHBORS)
//   E_MIN          16'h0800 energy floor (0.125); used only with NTC_ENERGY_FILTER_EN
// PORTS
//   clk            in   1       single clock; all state changes on rising edge
//   nrst           in   1       synchronous, active-high reset (1 = reset)
//   upd_req        in   1       level; held until upd_ack
//   upd_id/upd_cluster/upd_energy/upd_qvalue  in  WORD_WIDTH each  packet fields, sampled at grant
//   upd_ack        out  1       1-cycle done pulse
//   upd_new        out  1       valid with upd_ack: entry appended
//   upd_full       out  1       valid with upd_ack: table full, dropped
//   best_req       in   1       level; held until best_ack
//   best_ack       out  1       1-cycle done pulse
//   best_valid     out  1       valid with best_ack: a candidate found
//   best_id        out  WORD_WIDTH  winning neighbor ID (held until next best_ack)
//   best_qvalue    out  WORD_WIDTH  winning Q-value (held)
//   mem_index      out  IDX_W   shared bank index
//   mem_wr_en      out  1       write strobe to all four banks
//   mem_id_wr/mem_cluster_wr/mem_energy_wr/mem_q_wr  out  WORD_WIDTH  write data
//   mem_id_rd/mem_q_rd/mem_energy_rd  in  WORD_WIDTH  bank read data, 1-cycle synchronous read
//   neighbor_count out  IDX_W+1 valid entries (0..MAX_NEIGHBORS)
//   busy           out  1       FSM not in IDLE
// BEHAVIOUR
//   Reset: all outputs 0, neighbor_count 0, FSM IDLE, RR pointer favours UPD. Reset mid-op aborts; no write issued that cycle.
//   Grant (IDLE only): one request pending -> grant it. Both pending -> round-robin; pointer flips after each grant.
//   Fields are latched at grant. Request drop before ack is illegal.
//   States: IDLE, U_RD, U_CMP, U_WR, B_RD, B_CMP, ACK.
//   UPD, count==0: IDLE->U_WR (append at 0).
//   UPD scan: per entry i, U_RD drives mem_index=i; U_CMP compares mem_id_rd to upd_id.
//     Match -> U_WR at i, upd_new=0.
//     Miss, i<count-1 -> U_RD i+1.
//     Miss on last entry: count<MAX -> U_WR at count, upd_new=1; count==MAX -> ACK, upd_full=1, no write.
//   U_WR: mem_wr_en=1 for exactly one cycle; write data = latched fields; count increments on append; next ACK.
//   Latency (grant to ack): match at k = 2(k+1)+2 cycles; append after N entries = 2N+2; empty append = 2.
//   BEST: count==0 -> ACK, best_valid=0.
//     Else scan 0..count-1 (B_RD/B_CMP, 2 cycles/entry); candidate replaces best only if mem_q_rd > best (strict, unsigned).
//     Ties keep lowest index; Q==0 entries are still candidates.
//   ACK: exactly one of upd_ack/best_ack high for one cycle; next IDLE. Grants resume the cycle after ACK.
//   mem_index is 0 in IDLE; mem_wr_en only in U_WR. count saturates at MAX_NEIGHBORS, never wraps.
// CONFIGURATION
//   NTC_ENERGY_FILTER_EN defined: in B_CMP, entries with mem_energy_rd < E_MIN are skipped. All skipped -> best_valid=0.
//   Not defined: mem_energy_rd is ignored (port kept); E_MIN unused.
// STRUCTURE
//   neighbor_table_pkg: WORD_WIDTH, MAX_NEIGHBORS, IDX_W, Q2.14 constants (Q_ONE=16'h4000), state encodings, E_MIN default.
//   Sub-module ntc_rr_arbiter: 2-way round-robin; inputs upd_req, best_req, idle; outputs one-hot grant.
//   Rest is a single FSM plus index, count and best registers.
// TESTING
//   1 Empty table; UPD id=1 cl=2 en=16'h8000 q=16'h3000 -> mem_wr_en at index 0, upd_ack 2 cycles after grant, upd_new=1, count=1.
//   2 Repeat UPD id=1 with cl=3, en=16'h599a -> scan hits index 0; write at 0; upd_new=0; count stays 1; ack at grant+4.
//   3 Fill 16 IDs; UPD id=99 -> upd_full=1 with ack, no mem_wr_en, count=16.
//   4 Q=[16'h1000,16'h3000,16'h3000,16'h2000]; BEST -> best_id of index 1, best_qvalue=16'h3000, best_valid=1, ack at grant+9.
//   5 upd_req and best_req rise together, both held twice -> grant order UPD, BEST, UPD, BEST; never two acks in one cycle.
//   6 Assert nrst mid UPD scan -> next cycle all outputs 0, count 0, no write. With NTC_ENERGY_FILTER_EN, best entry energy 16'h0400 -> skipped, next-highest Q wins.

Source files
------------

// File: rtl/neighbor_table_pkg.sv
// Shared constants, types and state encoding for the neighbor-table controller.
// Build option: NTC_ENERGY_FILTER_EN enables the E_MIN energy floor in BEST scans.
`timescale 1ns/1ps
package neighbor_table_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int MAX_NEIGHBORS = 16;
  localparam int IDX_W         = $clog2(MAX_NEIGHBORS);

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [IDX_W:0]        cnt_t;

  // Unsigned Q2.14 fixed point
  localparam word_t Q_ONE   = 16'h4000;
  localparam word_t E_MIN   = 16'h0800;
  localparam cnt_t  MAX_CNT = cnt_t'(MAX_NEIGHBORS);

  typedef enum logic [2:0] {
    S_IDLE, S_U_RD, S_U_CMP, S_U_WR, S_B_RD, S_B_CMP, S_ACK
  } state_e;

  typedef enum logic {OP_UPD, OP_BEST} op_e;

  typedef struct packed {
    word_t id;
    word_t cluster;
    word_t energy;
    word_t qvalue;
  } pkt_t;

endpackage

// File: rtl/neighbor_table_ctrl_if.sv
// Shared bank bus: one index and write strobe for the four neighbor-table banks,
// plus their 1-cycle synchronous read data.
`timescale 1ns/1ps
interface neighbor_table_ctrl_if;
  import neighbor_table_pkg::*;

  idx_t  mem_index;
  logic  mem_wr_en;
  word_t mem_id_wr, mem_cluster_wr, mem_energy_wr, mem_q_wr;
  word_t mem_id_rd, mem_q_rd, mem_energy_rd;

  modport master (
    output mem_index, mem_wr_en, mem_id_wr, mem_cluster_wr, mem_energy_wr, mem_q_wr,
    input  mem_id_rd, mem_q_rd, mem_energy_rd
  );

  modport slave (
    input  mem_index, mem_wr_en, mem_id_wr, mem_cluster_wr, mem_energy_wr, mem_q_wr,
    output mem_id_rd, mem_q_rd, mem_energy_rd
  );
endinterface

// File: rtl/ntc_rr_arbiter.sv
// Two-way round-robin arbiter; grant[0] = UPD, grant[1] = BEST.
// Grants only while the controller is idle; pointer favours the loser after every grant.
`timescale 1ns/1ps
module ntc_rr_arbiter (
  input  logic       clk,
  input  logic       nrst,
  input  logic       upd_req,
  input  logic       best_req,
  input  logic       idle,
  output logic [1:0] grant
);

  logic favour_best_q, favour_best_d;

  always_comb begin
    grant         = 2'b00;
    favour_best_d = favour_best_q;
    if (idle) begin
      if (upd_req && best_req) grant = favour_best_q ? 2'b10 : 2'b01;
      else if (upd_req)        grant = 2'b01;
      else if (best_req)       grant = 2'b10;
    end
    if (grant[0]) favour_best_d = 1'b1;
    if (grant[1]) favour_best_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (nrst) favour_best_q <= 1'b0;
    else      favour_best_q <= favour_best_d;
  end

endmodule

// File: rtl/neighbor_table_ctrl.sv
// Neighbor-table sequencer: UPD (find-or-append) and BEST (max-Q scan) share the banks.
// Build option: NTC_ENERGY_FILTER_EN skips low-energy entries during BEST.
`timescale 1ns/1ps
module neighbor_table_ctrl
  import neighbor_table_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  upd_req,
  input  word_t upd_id,
  input  word_t upd_cluster,
  input  word_t upd_energy,
  input  word_t upd_qvalue,
  output logic  upd_ack,
  output logic  upd_new,
  output logic  upd_full,
  input  logic  best_req,
  output logic  best_ack,
  output logic  best_valid,
  output word_t best_id,
  output word_t best_qvalue,
  output cnt_t  neighbor_count,
  output logic  busy,
  neighbor_table_ctrl_if.master mem
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  idx_t   idx_q, idx_d;
  cnt_t   cnt_q, cnt_d;
  pkt_t   pkt_q, pkt_d;
  logic   new_q, new_d, full_q, full_d;
  logic   cand_found_q, cand_found_d;
  word_t  cand_q_q, cand_q_d, cand_id_q, cand_id_d;
  logic   best_valid_q, best_valid_d;
  word_t  best_id_q, best_id_d, best_q_q, best_q_d;

  logic [1:0] grant;
  logic       last_entry, energy_ok, take;

  ntc_rr_arbiter u_arb (
    .clk      (clk),
    .nrst     (nrst),
    .upd_req  (upd_req),
    .best_req (best_req),
    .idle     (state_q == S_IDLE),
    .grant    (grant)
  );

`ifdef NTC_ENERGY_FILTER_EN
  assign energy_ok = (mem.mem_energy_rd >= E_MIN);
`else
  logic unused_energy;
  assign unused_energy = ^mem.mem_energy_rd;
  assign energy_ok     = 1'b1;
`endif

  assign last_entry = (({1'b0, idx_q} + cnt_t'(1)) == cnt_q);
  // Strict compare: ties keep the earlier (lower-index) candidate
  assign take       = energy_ok && (!cand_found_q || (mem.mem_q_rd > cand_q_q));

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pkt_d        = pkt_q;
    new_d        = new_q;
    full_d       = full_q;
    cand_found_d = cand_found_q;
    cand_q_d     = cand_q_q;
    cand_id_d    = cand_id_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_q_d     = best_q_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant[0]) begin
          op_d   = OP_UPD;
          pkt_d  = {upd_id, upd_cluster, upd_energy, upd_qvalue};
          idx_d  = '0;
          full_d = 1'b0;
          new_d  = (cnt_q == '0);
          state_d = (cnt_q == '0) ? S_U_WR : S_U_RD;
        end else if (grant[1]) begin
          op_d         = OP_BEST;
          idx_d        = '0;
          cand_found_d = 1'b0;
          cand_q_d     = '0;
          cand_id_d    = '0;
          if (cnt_q == '0) begin
            best_valid_d = 1'b0;
            state_d      = S_ACK;
          end else begin
            state_d      = S_B_RD;
          end
        end
      end
      S_U_RD: state_d = S_U_CMP;
      S_U_CMP: begin
        if (mem.mem_id_rd == pkt_q.id) begin
          state_d = S_U_WR;
        end else if (!last_entry) begin
          idx_d   = idx_q + idx_t'(1);
          state_d = S_U_RD;
        end else if (cnt_q < MAX_CNT) begin
          idx_d   = idx_t'(cnt_q);
          new_d   = 1'b1;
          state_d = S_U_WR;
        end else begin
          full_d  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_U_WR: begin
        if (new_q && (cnt_q < MAX_CNT)) cnt_d = cnt_q + cnt_t'(1);
        state_d = S_ACK;
      end
      S_B_RD: state_d = S_B_CMP;
      S_B_CMP: begin
        if (take) begin
          cand_found_d = 1'b1;
          cand_q_d     = mem.mem_q_rd;
          cand_id_d    = mem.mem_id_rd;
        end
        if (last_entry) begin
          best_valid_d = cand_found_d;
          best_id_d    = cand_id_d;
          best_q_d     = cand_q_d;
          state_d      = S_ACK;
        end else begin
          idx_d   = idx_q + idx_t'(1);
          state_d = S_B_RD;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (nrst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_UPD;
      idx_q        <= '0;
      cnt_q        <= '0;
      pkt_q        <= '0;
      new_q        <= 1'b0;
      full_q       <= 1'b0;
      cand_found_q <= 1'b0;
      cand_q_q     <= '0;
      cand_id_q    <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_q_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pkt_q        <= pkt_d;
      new_q        <= new_d;
      full_q       <= full_d;
      cand_found_q <= cand_found_d;
      cand_q_q     <= cand_q_d;
      cand_id_q    <= cand_id_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_q_q     <= best_q_d;
    end
  end

  assign upd_ack        = (state_q == S_ACK) && (op_q == OP_UPD);
  assign best_ack       = (state_q == S_ACK) && (op_q == OP_BEST);
  assign upd_new        = upd_ack && new_q;
  assign upd_full       = upd_ack && full_q;
  assign best_valid     = best_ack && best_valid_q;
  assign best_id        = best_id_q;
  assign best_qvalue    = best_q_q;
  assign neighbor_count = cnt_q;
  assign busy           = (state_q != S_IDLE);

  // A reset arriving during U_WR must not let the pending write reach the banks
  assign mem.mem_wr_en      = (state_q == S_U_WR) && !nrst;
  assign mem.mem_index      = (state_q == S_IDLE) ? '0 : idx_q;
  assign mem.mem_id_wr      = pkt_q.id;
  assign mem.mem_cluster_wr = pkt_q.cluster;
  assign mem.mem_energy_wr  = pkt_q.energy;
  assign mem.mem_q_wr       = pkt_q.qvalue;

endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// Scoreboard bench for neighbor_table_ctrl: a list-based table model predicts each ack;
// a monitor pops and compares whenever an ack appears.
`timescale 1ns/1ps
module tb_neighbor_table_ctrl;
  import neighbor_table_pkg::*;

  logic  clk = 1'b0;
  logic  nrst = 1'b1;
  logic  upd_req = 1'b0, best_req = 1'b0;
  word_t upd_id = '0, upd_cluster = '0, upd_energy = '0, upd_qvalue = '0;
  logic  upd_ack, upd_new, upd_full, best_ack, best_valid, busy;
  word_t best_id, best_qvalue;
  cnt_t  neighbor_count;

  neighbor_table_ctrl_if mem_bus ();

  neighbor_table_ctrl dut (
    .clk(clk), .nrst(nrst),
    .upd_req(upd_req), .upd_id(upd_id), .upd_cluster(upd_cluster),
    .upd_energy(upd_energy), .upd_qvalue(upd_qvalue),
    .upd_ack(upd_ack), .upd_new(upd_new), .upd_full(upd_full),
    .best_req(best_req), .best_ack(best_ack), .best_valid(best_valid),
    .best_id(best_id), .best_qvalue(best_qvalue),
    .neighbor_count(neighbor_count), .busy(busy), .mem(mem_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: synchronous write, 1-cycle synchronous read
  word_t b_id [MAX_NEIGHBORS];
  word_t b_en [MAX_NEIGHBORS];
  word_t b_q  [MAX_NEIGHBORS];
  always @(posedge clk) begin
    if (mem_bus.mem_wr_en) begin
      b_id[mem_bus.mem_index] <= mem_bus.mem_id_wr;
      b_en[mem_bus.mem_index] <= mem_bus.mem_energy_wr;
      b_q[mem_bus.mem_index]  <= mem_bus.mem_q_wr;
    end
    mem_bus.mem_id_rd     <= b_id[mem_bus.mem_index];
    mem_bus.mem_energy_rd <= b_en[mem_bus.mem_index];
    mem_bus.mem_q_rd      <= b_q[mem_bus.mem_index];
  end

  int total = 0, bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: table as an ordered list of entries
  typedef struct { word_t id, cl, en, q; } ent_t;
  typedef struct {
    bit    is_best, new_f, full_f, bvalid;
    int    wrote, widx, cnt, lat;
    word_t wid, wcl, wen, wq, bid, bq;
  } exp_t;

  ent_t tbl[$];
  exp_t sb[$];

  function automatic void exp_upd(word_t id, word_t cl, word_t en, word_t q);
    exp_t e = '{default: 0};
    int   hit = -1;
    foreach (tbl[i]) if (hit < 0 && tbl[i].id == id) hit = i;
    e.wid = id; e.wcl = cl; e.wen = en; e.wq = q;
    if (hit >= 0) begin
      e.wrote = 1; e.widx = hit; e.lat = 2 * (hit + 1) + 2;
      tbl[hit] = '{id: id, cl: cl, en: en, q: q};
    end else if (tbl.size() < MAX_NEIGHBORS) begin
      e.wrote = 1; e.new_f = 1; e.widx = tbl.size(); e.lat = 2 * tbl.size() + 2;
      tbl.push_back('{id: id, cl: cl, en: en, q: q});
    end else begin
      e.full_f = 1; e.lat = 2 * MAX_NEIGHBORS + 1;
    end
    e.cnt = tbl.size();
    sb.push_back(e);
  endfunction

  function automatic void exp_best();
    exp_t e = '{default: 0};
    bit   ok;
    e.is_best = 1;
    e.cnt     = tbl.size();
    e.lat     = (tbl.size() == 0) ? 1 : 2 * tbl.size() + 1;
    foreach (tbl[i]) begin
`ifdef NTC_ENERGY_FILTER_EN
      ok = (tbl[i].en >= 16'h0800);
`else
      ok = 1'b1;
`endif
      if (ok && (!e.bvalid || tbl[i].q > e.bq)) begin
        e.bvalid = 1; e.bid = tbl[i].id; e.bq = tbl[i].q;
      end
    end
    sb.push_back(e);
  endfunction

  // Monitor: grant cycle inferred from busy rising (grant is the IDLE cycle before)
  initial begin
    int    grant_cyc = 0, wr_n = 0, w_idx = 0;
    bit    prev_busy = 0;
    word_t w_id = '0, w_cl = '0, w_en = '0, w_q = '0;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        grant_cyc = cyc - 1;
        wr_n      = 0;
      end
      prev_busy = busy;
      if (mem_bus.mem_wr_en) begin
        wr_n++;
        w_idx = int'(mem_bus.mem_index);
        w_id = mem_bus.mem_id_wr; w_cl = mem_bus.mem_cluster_wr;
        w_en = mem_bus.mem_energy_wr; w_q = mem_bus.mem_q_wr;
      end
      if (upd_ack || best_ack) begin
        check("single_ack", 64'(upd_ack && best_ack), 64'(0));
        check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_kind", 64'(best_ack), 64'(e.is_best));
          check("latency", 64'(cyc - grant_cyc), 64'(e.lat));
          check("count", 64'(neighbor_count), 64'(e.cnt));
          if (!e.is_best) begin
            check("upd_new", 64'(upd_new), 64'(e.new_f));
            check("upd_full", 64'(upd_full), 64'(e.full_f));
            check("wr_pulses", 64'(wr_n), 64'(e.wrote));
            if (e.wrote != 0) begin
              check("wr_index", 64'(w_idx), 64'(e.widx));
              check("wr_data", {w_id, w_cl, w_en, w_q}, {e.wid, e.wcl, e.wen, e.wq});
            end
          end else begin
            check("best_valid", 64'(best_valid), 64'(e.bvalid));
            if (e.bvalid) check("best_sel", {32'h0, best_id, best_qvalue}, {32'h0, e.bid, e.bq});
          end
        end
      end
    end
  end

  task automatic drive_upd(word_t id, word_t cl, word_t en, word_t q);
    bit got = 0;
    @(posedge clk); #1;
    upd_id = id; upd_cluster = cl; upd_energy = en; upd_qvalue = q;
    upd_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (upd_ack) begin got = 1; break; end
    end
    upd_req = 1'b0;
    check("upd_ack_seen", 64'(got), 64'(1));
  endtask

  task automatic drive_best();
    bit got = 0;
    @(posedge clk); #1;
    best_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (best_ack) begin got = 1; break; end
    end
    best_req = 1'b0;
    check("best_ack_seen", 64'(got), 64'(1));
  endtask

  task automatic run_upd(word_t id, word_t cl, word_t en, word_t q);
    exp_upd(id, cl, en, q);
    drive_upd(id, cl, en, q);
  endtask

  task automatic run_best();
    exp_best();
    drive_best();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1 nrst = 1'b0;
    tbl.delete();
  endtask

  task automatic check_quiet(string tag);
    @(negedge clk);
    check({tag, "_ctrl"}, 64'({upd_ack, upd_new, upd_full, best_ack, best_valid,
          mem_bus.mem_wr_en, busy, mem_bus.mem_index, neighbor_count}), 64'(0));
    check({tag, "_best"}, {32'h0, best_id, best_qvalue}, 64'(0));
    check({tag, "_wdata"}, {mem_bus.mem_id_wr, mem_bus.mem_cluster_wr,
          mem_bus.mem_energy_wr, mem_bus.mem_q_wr}, 64'(0));
  endtask

  task automatic wait_busy();
    bit got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy) begin got = 1; break; end
    end
    check("busy_seen", 64'(got), 64'(1));
  endtask

  function automatic word_t pick_q();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'h1000;
      2: return 16'h3000;
      3: return Q_ONE;
      default: return word_t'($urandom_range(0, 16'hffff));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 nrst = 1'b0;
    check_quiet("reset");

    // Simultaneous requesters straight after reset: UPD, BEST, UPD, BEST
    exp_upd(16'd1, 16'd2, 16'h8000, 16'h3000);
    exp_best();
    exp_upd(16'd1, 16'd3, 16'h599a, 16'h3000);
    exp_best();
    fork
      begin
        drive_upd(16'd1, 16'd2, 16'h8000, 16'h3000);
        drive_upd(16'd1, 16'd3, 16'h599a, 16'h3000);
      end
      begin
        drive_best();
        drive_best();
      end
    join

    // Fill the table, then an unknown ID is dropped
    do_reset();
    for (int i = 1; i <= MAX_NEIGHBORS; i++)
      run_upd(word_t'(i), word_t'(i + 100), 16'h8000, word_t'(i * 16'h0100));
    run_upd(16'd99, 16'd7, 16'h8000, 16'h2000);
    run_best();

    // Max-Q selection with a tie; then starve the winner of energy
    do_reset();
    run_best();
    run_upd(16'd10, 16'd1, 16'h8000, 16'h1000);
    run_upd(16'd11, 16'd1, 16'h8000, 16'h3000);
    run_upd(16'd12, 16'd1, 16'h8000, 16'h3000);
    run_upd(16'd13, 16'd1, 16'h8000, 16'h2000);
    run_best();
    run_upd(16'd11, 16'd1, 16'h0400, 16'h3000);
    run_best();

    // Reset in the middle of a scan
    @(posedge clk); #1;
    upd_id = 16'd77; upd_cluster = 16'd5; upd_energy = 16'h8000; upd_qvalue = 16'h1234;
    upd_req = 1'b1;
    wait_busy();
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1 nrst = 1'b0; upd_req = 1'b0;
    tbl.delete();
    check_quiet("rst_scan");

    // Reset landing on the write cycle must suppress the write
    @(posedge clk); #1;
    upd_id = 16'd5; upd_cluster = 16'd6; upd_energy = 16'h8000; upd_qvalue = 16'h2222;
    upd_req = 1'b1;
    wait_busy();
    nrst = 1'b1;
    #1 check("rst_wr_gate", 64'(mem_bus.mem_wr_en), 64'(0));
    @(posedge clk); #1 nrst = 1'b0; upd_req = 1'b0;
    check_quiet("rst_wr");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_best();
      end else begin
        run_upd(word_t'($urandom_range(1, 20)), word_t'($urandom_range(0, 16'hffff)),
                ($urandom_range(0, 1) != 0) ? word_t'($urandom_range(0, 16'h07ff))
                                            : word_t'($urandom_range(16'h0800, 16'hffff)),
                pick_q());
      end
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
